snow64_memory_bus_guard: RTL

- Responder end of the read-FIFO/write-FIFO memory-access protocol.
- Accepts single-element requests from one read FIFO and one write FIFO, and arbitrates between them.
- Issues one transaction at a time to the external memory bus, then returns cmd_accepted and valid/data pulses to the requester.
- Sits between the memory-access FIFOs and the memory controller; one outstanding transaction maximum.

---
 rtl/snow64_memory_access_fifo_pkg.sv | 13 +
 rtl/snow64_memory_bus_guard_pkg.sv | 43 ++++
 rtl/snow64_memory_bus_guard_arbiter.sv | 45 ++++
 rtl/snow64_memory_bus_guard.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/snow64_memory_access_fifo_pkg.sv
// Shared types of the read-FIFO/write-FIFO memory-access protocol.
// Latency: n/a (types only).
// Backpressure: n/a.
// Provides CpuAddr (CPU byte address) and LarData (one 32-byte line).
package PkgSnow64MemoryAccessFifo;

    localparam int WIDTH__CPU_ADDR = 64;
    localparam int WIDTH__LAR_DATA = 256;

    typedef logic [WIDTH__CPU_ADDR-1:0] CpuAddr;
    typedef logic [WIDTH__LAR_DATA-1:0] LarData;

endpackage : PkgSnow64MemoryAccessFifo

// File: rtl/snow64_memory_bus_guard_pkg.sv
// Types and constants of the memory bus guard.
// Latency: n/a (types only).
// Backpressure: n/a.
// Holds the FSM state enum, request type, memory-side port structs and the
// line-address LSB position.
package PkgSnow64MemoryBusGuard;

    import PkgSnow64MemoryAccessFifo::*;

    typedef enum logic [1:0] {
        StIdle       = 2'd0,
        StIssueToMem = 2'd1,
        StWaitForMem = 2'd2
    } MemBusGuardState;

    typedef enum logic {
        ReqRead  = 1'b0,
        ReqWrite = 1'b1
    } MemReqType;

    // Memory controller -> guard.
    typedef struct packed {
        logic   ack;
        logic   done;
        LarData rd_data;
    } PortIn;

    // Guard -> memory controller.
    typedef struct packed {
        logic   req;
        logic   we;
        CpuAddr addr;
        LarData wr_data;
    } PortOut;

    // Number of byte-offset bits inside one data line.
    function automatic int line_addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    localparam int LSB_POS__LINE_ADDR = line_addr_lsb(WIDTH__LAR_DATA);

endpackage : PkgSnow64MemoryBusGuard

// File: rtl/snow64_memory_bus_guard_arbiter.sv
// Read/write grant selection for the memory bus guard.
// Latency: combinational grant; optional pointer updates on the grant edge.
// Backpressure: grants only while i_en (guard idle); losers stay pending.
// Ports: i_en (guard can accept), i_rd_req/i_wr_req, o_grant_rd/o_grant_wr.
// With SNOW64_MEMORY_BUS_GUARD_ROUND_ROBIN_EN defined, ties alternate and
// i_clk/i_rst clock the pointer; otherwise writes always win a tie.
module snow64_memory_bus_guard_arbiter (
`ifdef SNOW64_MEMORY_BUS_GUARD_ROUND_ROBIN_EN
    input  logic i_clk,
    input  logic i_rst,
`endif
    input  logic i_en,
    input  logic i_rd_req,
    input  logic i_wr_req,
    output logic o_grant_rd,
    output logic o_grant_wr
);

`ifdef SNOW64_MEMORY_BUS_GUARD_ROUND_ROBIN_EN
    // 1 = the most recent grant went to the read side. Resetting to 1 makes
    // the first tie go to the write side.
    logic r_last_rd;

    always_comb begin
        o_grant_wr = i_en & i_wr_req & (~i_rd_req | r_last_rd);
        o_grant_rd = i_en & i_rd_req & (~i_wr_req | ~r_last_rd);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_rd <= 1'b1;
        end else if (o_grant_rd | o_grant_wr) begin
            r_last_rd <= o_grant_rd;
        end
    end
`else
    // Fixed write priority keeps a read from overtaking an older write to
    // the same line.
    always_comb begin
        o_grant_wr = i_en & i_wr_req;
        o_grant_rd = i_en & i_rd_req & ~i_wr_req;
    end
`endif

endmodule : snow64_memory_bus_guard_arbiter

// File: rtl/snow64_memory_bus_guard.sv
// Responder for the read/write memory-access FIFOs: arbitrates and issues one
// memory transaction at a time.
// Latency: req sampled at N -> cmd_accepted at N+1 -> valid one cycle after done
//          (min 3 cycles req-to-valid counting the request cycle).
// Backpressure: one outstanding transaction; requests wait while not idle,
//          mem_req is held until in_mem_ack.
// Ports: clk/rst (async active-high); in_rd_* / out_rd_* read FIFO side;
//        in_wr_* / out_wr_* write FIFO side; out_mem_* / in_mem_* memory side.
// Option macro: SNOW64_MEMORY_BUS_GUARD_ROUND_ROBIN_EN (round-robin ties).
module snow64_memory_bus_guard
    import PkgSnow64MemoryAccessFifo::*;
    import PkgSnow64MemoryBusGuard::*;
#(
    parameter int CPU_ADDR_WIDTH = $bits(CpuAddr),
    parameter int DATA_WIDTH     = $bits(LarData)
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      in_rd_req,
    input  logic [CPU_ADDR_WIDTH-1:0] in_rd_addr,
    output logic                      out_rd_valid,
    output logic                      out_rd_cmd_accepted,
    output logic [DATA_WIDTH-1:0]     out_rd_data,

    input  logic                      in_wr_req,
    input  logic [CPU_ADDR_WIDTH-1:0] in_wr_addr,
    input  logic [DATA_WIDTH-1:0]     in_wr_data,
    output logic                      out_wr_valid,
    output logic                      out_wr_cmd_accepted,

    output logic                      out_mem_req,
    output logic                      out_mem_we,
    output logic [CPU_ADDR_WIDTH-1:0] out_mem_addr,
    output logic [DATA_WIDTH-1:0]     out_mem_wr_data,
    input  logic                      in_mem_ack,
    input  logic                      in_mem_done,
    input  logic [DATA_WIDTH-1:0]     in_mem_rd_data
);

    localparam int LSB = line_addr_lsb(DATA_WIDTH);
    localparam logic [CPU_ADDR_WIDTH-1:0] ADDR_MASK =
        ~((CPU_ADDR_WIDTH'(1) << LSB) - CPU_ADDR_WIDTH'(1));

    MemBusGuardState           r_state;
    MemReqType                 r_type;
    logic [CPU_ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]     r_wr_data;
    logic [DATA_WIDTH-1:0]     r_rd_data;
    logic                      r_mem_req;
    logic                      r_rd_valid;
    logic                      r_wr_valid;
    logic                      r_rd_cmd_acc;
    logic                      r_wr_cmd_acc;

    logic w_idle;
    logic w_grant_rd;
    logic w_grant_wr;
    logic w_complete;

    assign w_idle = (r_state == StIdle);

    snow64_memory_bus_guard_arbiter u_arbiter (
`ifdef SNOW64_MEMORY_BUS_GUARD_ROUND_ROBIN_EN
        .i_clk      (clk),
        .i_rst      (rst),
`endif
        .i_en       (w_idle),
        .i_rd_req   (in_rd_req),
        .i_wr_req   (in_wr_req),
        .o_grant_rd (w_grant_rd),
        .o_grant_wr (w_grant_wr)
    );

    // Ack and done together in IssueToMem skip WaitForMem entirely.
    assign w_complete = ((r_state == StIssueToMem) && in_mem_ack && in_mem_done)
                     || ((r_state == StWaitForMem) && in_mem_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_type       <= ReqRead;
            r_addr       <= '0;
            r_wr_data    <= '0;
            r_rd_data    <= '0;
            r_mem_req    <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_wr_valid   <= 1'b0;
            r_rd_cmd_acc <= 1'b0;
            r_wr_cmd_acc <= 1'b0;
        end else begin
            // All handshake outputs are single-cycle pulses.
            r_rd_valid   <= 1'b0;
            r_wr_valid   <= 1'b0;
            r_rd_cmd_acc <= 1'b0;
            r_wr_cmd_acc <= 1'b0;

            case (r_state)
                StIdle: begin
                    if (w_grant_wr || w_grant_rd) begin
                        r_state      <= StIssueToMem;
                        r_mem_req    <= 1'b1;
                        r_type       <= w_grant_wr ? ReqWrite : ReqRead;
                        r_addr       <= (w_grant_wr ? in_wr_addr : in_rd_addr) & ADDR_MASK;
                        r_wr_data    <= w_grant_wr ? in_wr_data : '0;
                        r_rd_cmd_acc <= w_grant_rd;
                        r_wr_cmd_acc <= w_grant_wr;
                    end
                end
                StIssueToMem: begin
                    if (in_mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= StWaitForMem;
                    end
                end
                StWaitForMem: begin
                end
                default: begin
                    r_state   <= StIdle;
                    r_mem_req <= 1'b0;
                end
            endcase

            // Completion overrides the IssueToMem -> WaitForMem move above.
            if (w_complete) begin
                r_state <= StIdle;
                if (r_type == ReqRead) begin
                    r_rd_data  <= in_mem_rd_data;
                    r_rd_valid <= 1'b1;
                end else begin
                    r_wr_valid <= 1'b1;
                end
            end
        end
    end

    assign out_rd_valid        = r_rd_valid;
    assign out_rd_cmd_accepted = r_rd_cmd_acc;
    assign out_rd_data         = r_rd_data;
    assign out_wr_valid        = r_wr_valid;
    assign out_wr_cmd_accepted = r_wr_cmd_acc;
    assign out_mem_req         = r_mem_req;
    assign out_mem_we          = (r_type == ReqWrite);
    assign out_mem_addr        = r_addr;
    assign out_mem_wr_data     = r_wr_data;

endmodule : snow64_memory_bus_guard
